// File: rtl/pic_param_ctrl.sv
// pic_param_ctrl: parametrised 8259-style interrupt controller with edge/level
// triggering, fixed or rotating priority, nested ISR masking, AEOI or
// commanded EOI, and a two-pulse INTA vector handshake.
// Optional build macro: PIC_SPECIAL_MASK_EN implements CTRL bit2 (SMM).
module pic_param_ctrl #(
    parameter int NUM_IRQ = 8,
    parameter int ID_W    = $clog2(NUM_IRQ),
    parameter int VEC_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq_i,
    input  logic               cfg_we,
    input  logic               cfg_re,
    input  logic [2:0]         cfg_addr,
    input  logic [31:0]        cfg_wdata,
    output logic [31:0]        cfg_rdata,
    output logic               int_o,
    input  logic               inta_i,
    output logic [VEC_W-1:0]   vec_o,
    output logic               vec_valid_o,
    output logic               busy_o
);

    // state | meaning
    // IDLE  | no handshake; int_o follows arbitration
    // ACK1  | grant cycle: latch winner, set ISR, clear edge IRR bit
    // WAIT2 | busy, waiting for second INTA
    // ACK2  | vector strobed; AEOI applied on exit
    typedef enum logic [1:0] {S_IDLE, S_ACK1, S_WAIT2, S_ACK2} state_t;

`ifdef PIC_SPECIAL_MASK_EN
    localparam logic [2:0] CTRL_WMASK = 3'b111;
`else
    localparam logic [2:0] CTRL_WMASK = 3'b011;
`endif

    state_t               state_q;
    logic [NUM_IRQ-1:0]   mask_q, trig_q, irr_q, irr_d, isr_q, isr_d, irq_prev_q;
    logic [VEC_W-1:0]     vbase_q, vec_q;
    logic [2:0]           ctrl_q;
    logic [ID_W-1:0]      last_id_q, last_id_d, grant_id_q;
    logic                 int_q, vec_valid_q, busy_q;
    logic [31:0]          rdata_q, rdata_d;

    logic [ID_W-1:0]      rot_base;
    logic [NUM_IRQ-1:0]   smm_mask, nest_req;
    logic                 cand_found, nest_found, top_found, cand_ok;
    logic [ID_W-1:0]      cand_id, top_id, nest_id_unused;
    logic [5:0]           cand_off, nest_off, top_off_unused;
    logic                 eoi_wr;
    logic [NUM_IRQ-1:0]   eoi_sel, grant_sel;
    logic [ID_W-1:0]      eoi_id;
    logic                 unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NUM_IRQ) sum = sum - NUM_IRQ;
        return ID_W'(sum);
    endfunction

    // Lowest offset from base wins; off is the priority rank (0 = highest).
    function automatic void pick_first(
        input  logic [NUM_IRQ-1:0] req,
        input  logic [ID_W-1:0]    base,
        output logic               found,
        output logic [ID_W-1:0]    id,
        output logic [5:0]         off
    );
        found = 1'b0;
        id    = '0;
        off   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (req[rot_idx(base, i)]) begin
                found = 1'b1;
                id    = rot_idx(base, i);
                off   = 6'(i);
            end
        end
    endfunction

`ifdef PIC_SPECIAL_MASK_EN
    assign smm_mask = ctrl_q[2] ? mask_q : '0;
`else
    assign smm_mask = '0;
`endif
    assign nest_req = isr_q & ~smm_mask;

    // Priority resolution for request candidate, nesting level and EOI target
    always_comb begin
        rot_base = '0;
        if (ctrl_q[1]) begin
            rot_base = (last_id_q == ID_W'(NUM_IRQ - 1)) ? '0 : last_id_q + ID_W'(1);
        end
        pick_first(irr_q & ~mask_q, rot_base, cand_found, cand_id, cand_off);
        pick_first(nest_req, rot_base, nest_found, nest_id_unused, nest_off);
        pick_first(isr_q, rot_base, top_found, top_id, top_off_unused);
        cand_ok = cand_found && (!nest_found || (cand_off < nest_off));
    end

    // Next IRR/ISR/last_id and read-data mux; EOI clear precedes the ACK1 set
    always_comb begin
        eoi_wr    = cfg_we && (cfg_addr == 3'd4);
        eoi_id    = cfg_wdata[8] ? cfg_wdata[ID_W-1:0] : top_id;
        eoi_sel   = '0;
        if (cfg_wdata[8]) eoi_sel = NUM_IRQ'(1) << cfg_wdata[ID_W-1:0];
        else if (top_found) eoi_sel = NUM_IRQ'(1) << top_id;
        grant_sel = '0;
        if (state_q == S_ACK1 && cand_found) grant_sel = NUM_IRQ'(1) << cand_id;

        isr_d     = isr_q;
        last_id_d = last_id_q;
        if (eoi_wr && |(isr_q & eoi_sel)) begin
            isr_d     = isr_d & ~eoi_sel;
            last_id_d = eoi_id;
        end
        isr_d = isr_d | grant_sel;
        if (state_q == S_ACK2 && ctrl_q[0]) begin
            isr_d     = isr_d & ~(NUM_IRQ'(1) << grant_id_q);
            last_id_d = grant_id_q;
        end

        irr_d = (trig_q & irq_i) |
                (~trig_q & ((irr_q & ~grant_sel) | (irq_i & ~irq_prev_q)));

        rdata_d = '0;
        if (cfg_re) begin
            case (cfg_addr)
                3'd0:    rdata_d = 32'(mask_q);
                3'd1:    rdata_d = 32'(trig_q);
                3'd2:    rdata_d = 32'(vbase_q);
                3'd3:    rdata_d = 32'(ctrl_q);
                3'd5:    rdata_d = 32'(irr_q);
                3'd6:    rdata_d = 32'(isr_q);
                default: rdata_d = '0;
            endcase
        end
    end

    // Register file, request/service registers and edge-detect history
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_q     <= '1;
            trig_q     <= '0;
            vbase_q    <= '0;
            ctrl_q     <= '0;
            irr_q      <= '0;
            isr_q      <= '0;
            irq_prev_q <= '0;
            last_id_q  <= ID_W'(NUM_IRQ - 1);
            rdata_q    <= '0;
        end else begin
            irq_prev_q <= irq_i;
            irr_q      <= irr_d;
            isr_q      <= isr_d;
            last_id_q  <= last_id_d;
            rdata_q    <= rdata_d;
            if (cfg_we) begin
                case (cfg_addr)
                    3'd0:    mask_q  <= cfg_wdata[NUM_IRQ-1:0];
                    3'd1:    trig_q  <= cfg_wdata[NUM_IRQ-1:0];
                    3'd2:    vbase_q <= cfg_wdata[VEC_W-1:0];
                    3'd3:    ctrl_q  <= cfg_wdata[2:0] & CTRL_WMASK;
                    default: ;
                endcase
            end
        end
    end

    // INTA handshake FSM with registered int/vector/busy outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            grant_id_q  <= '0;
            int_q       <= 1'b0;
            vec_q       <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            vec_valid_q <= 1'b0;
            int_q       <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (inta_i) begin
                        state_q <= S_ACK1;
                        busy_q  <= 1'b1;
                    end else begin
                        int_q <= cand_ok;
                    end
                end
                S_ACK1: begin
                    grant_id_q <= cand_found ? cand_id : ID_W'(NUM_IRQ - 1);
                    state_q    <= S_WAIT2;
                end
                S_WAIT2: begin
                    if (inta_i) begin
                        state_q     <= S_ACK2;
                        vec_q       <= vbase_q + VEC_W'(grant_id_q);
                        vec_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                S_ACK2:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cfg_rdata   = rdata_q;
    assign int_o       = int_q;
    assign vec_o       = vec_q;
    assign vec_valid_o = vec_valid_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pic_param_ctrl.sv
// tb_pic_param_ctrl: directed scenarios plus randomized traffic against a
// behavioural model of the interrupt controller.
module tb_pic_param_ctrl;
    localparam int N = 8;
`ifdef PIC_SPECIAL_MASK_EN
    localparam bit SMM_EN = 1'b1;
`else
    localparam bit SMM_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] irq_i = '0;
    logic         cfg_we = 1'b0, cfg_re = 1'b0;
    logic [2:0]   cfg_addr = '0;
    logic [31:0]  cfg_wdata = '0;
    logic [31:0]  cfg_rdata;
    logic         int_o, vec_valid_o, busy_o;
    logic         inta_i = 1'b0;
    logic [7:0]   vec_o;

    int vectors = 0;
    int miscompares = 0;

    // behavioural model state
    bit [N-1:0] m_mask, m_trig, m_irr, m_isr, m_prev;
    int         m_vbase, m_last, m_phase, m_grant, m_vec;
    bit         m_aeoi, m_rot, m_smm, m_int, m_vv, m_busy;
    bit [31:0]  m_rdata;

    pic_param_ctrl #(.NUM_IRQ(N), .VEC_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .irq_i(irq_i),
        .cfg_we(cfg_we), .cfg_re(cfg_re), .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .int_o(int_o), .inta_i(inta_i), .vec_o(vec_o),
        .vec_valid_o(vec_valid_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic int rank(input int l);
        if (m_rot) return (l - (m_last + 1) + 2 * N) % N;
        return l;
    endfunction

    function automatic int top(input bit [N-1:0] v);
        int best = -1;
        for (int l = 0; l < N; l++)
            if (v[l] && (best < 0 || rank(l) < rank(best))) best = l;
        return best;
    endfunction

    task automatic model_reset();
        m_mask = '1; m_trig = '0; m_irr = '0; m_isr = '0; m_prev = '0;
        m_vbase = 0; m_aeoi = 0; m_rot = 0; m_smm = 0; m_last = N - 1;
        m_phase = 0; m_grant = 0; m_int = 0; m_vv = 0; m_busy = 0; m_vec = 0; m_rdata = '0;
    endtask

    task automatic model_step();
        bit [N-1:0] rise, gsel, n_isr, n_irr;
        int cand, ntop, tgt, n_last, n_phase, n_grant, n_vec;
        bit ok, n_int, n_vv, n_busy;
        rise = irq_i & ~m_prev;
        cand = top(m_irr & ~m_mask);
        ntop = top(m_smm ? (m_isr & ~m_mask) : m_isr);
        ok = (cand >= 0) && (ntop < 0 || rank(cand) < rank(ntop));
        n_isr = m_isr; n_last = m_last; gsel = '0; n_phase = m_phase; n_grant = m_grant;
        n_int = 0; n_vv = 0; n_busy = m_busy; n_vec = m_vec;
        if (cfg_we && cfg_addr == 3'd4) begin
            tgt = cfg_wdata[8] ? int'(cfg_wdata[2:0]) : top(m_isr);
            if (tgt >= 0 && m_isr[tgt]) begin n_isr[tgt] = 0; n_last = tgt; end
        end
        case (m_phase)
            0: if (inta_i) begin n_phase = 1; n_busy = 1; end else n_int = ok;
            1: begin
                n_grant = (cand >= 0) ? cand : N - 1;
                if (cand >= 0) begin n_isr[cand] = 1; gsel[cand] = 1; end
                n_phase = 2;
            end
            2: if (inta_i) begin n_phase = 3; n_vec = (m_vbase + m_grant) % 256; n_vv = 1; n_busy = 0; end
            default: begin
                if (m_aeoi) begin n_isr[m_grant] = 0; n_last = m_grant; end
                n_phase = 0;
            end
        endcase
        for (int l = 0; l < N; l++)
            n_irr[l] = m_trig[l] ? irq_i[l] : ((m_irr[l] && !gsel[l]) || rise[l]);
        m_rdata = '0;
        if (cfg_re) begin
            case (cfg_addr)
                3'd0: m_rdata = 32'(m_mask);
                3'd1: m_rdata = 32'(m_trig);
                3'd2: m_rdata = 32'(m_vbase);
                3'd3: m_rdata = {29'd0, m_smm, m_rot, m_aeoi};
                3'd5: m_rdata = 32'(m_irr);
                3'd6: m_rdata = 32'(m_isr);
                default: m_rdata = '0;
            endcase
        end
        if (cfg_we) begin
            case (cfg_addr)
                3'd0: m_mask = cfg_wdata[N-1:0];
                3'd1: m_trig = cfg_wdata[N-1:0];
                3'd2: m_vbase = int'(cfg_wdata[7:0]);
                3'd3: begin m_aeoi = cfg_wdata[0]; m_rot = cfg_wdata[1]; m_smm = SMM_EN && cfg_wdata[2]; end
                default: ;
            endcase
        end
        m_prev = irq_i; m_irr = n_irr; m_isr = n_isr; m_last = n_last; m_phase = n_phase;
        m_grant = n_grant; m_int = n_int; m_vv = n_vv; m_busy = n_busy; m_vec = n_vec;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        cfg_we = 1'b0; cfg_re = 1'b0; inta_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; irq_i = '0; cfg_we = 0; cfg_re = 0; inta_i = 0;
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
        tick();
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] d);
        cfg_re = 1'b1; cfg_addr = a;
        tick();
        d = cfg_rdata;
    endtask

    task automatic handshake(output logic vv, output logic [7:0] v);
        inta_i = 1'b1; tick();
        tick();
        inta_i = 1'b1; tick();
        vv = vec_valid_o; v = vec_o;
        tick();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        vectors++; if ({int_o, vec_valid_o, busy_o} !== 3'b000) begin miscompares++;
            $display("FAIL reset_outs: got int/vv/busy=%b want 000", {int_o, vec_valid_o, busy_o}); end
        vectors++; if (vec_o !== 8'h00 || cfg_rdata !== 32'h0) begin miscompares++;
            $display("FAIL reset_data: got vec=%h rdata=%h want 0", vec_o, cfg_rdata); end
        rd(3'd0, d);
        vectors++; if (d !== 32'hFF) begin miscompares++; $display("FAIL reset_mask: got %h want ff", d); end
        rd(3'd6, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL reset_isr: got %h want 0", d); end
    endtask

    task automatic test_single();
        logic [31:0] d; logic vv; logic [7:0] v;
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40);
        irq_i[3] = 1'b1; tick(); irq_i[3] = 1'b0;
        vectors++; if (int_o !== 1'b0) begin miscompares++; $display("FAIL single_int_early: got %b want 0", int_o); end
        tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL single_int: got %b want 1", int_o); end
        inta_i = 1'b1; tick();
        vectors++; if ({int_o, busy_o} !== 2'b01) begin miscompares++;
            $display("FAIL single_ack1: got int/busy=%b want 01", {int_o, busy_o}); end
        tick();
        inta_i = 1'b1; tick();
        vectors++; if (vec_valid_o !== 1'b1 || vec_o !== 8'h43 || busy_o !== 1'b0) begin miscompares++;
            $display("FAIL single_vec: got vv=%b vec=%h busy=%b want 1 43 0", vec_valid_o, vec_o, busy_o); end
        tick();
        vectors++; if (vec_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_strobe_len: got %b want 0", vec_valid_o); end
        rd(3'd6, d);
        vectors++; if (d !== 32'h08) begin miscompares++; $display("FAIL single_isr: got %h want 08", d); end
        rd(3'd5, d);
        vectors++; if (d !== 32'h00) begin miscompares++; $display("FAIL single_irr: got %h want 00", d); end
        handshake(vv, v);
    endtask

    task automatic test_nested();
        logic vv; logic [7:0] v;
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40);
        irq_i[5] = 1'b1; irq_i[2] = 1'b1; tick(); irq_i = '0; tick();
        handshake(vv, v);
        vectors++; if (vv !== 1'b1 || v !== 8'h42) begin miscompares++;
            $display("FAIL nested_first: got vv=%b vec=%h want 1 42", vv, v); end
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (int_o !== 1'b0) begin miscompares++; $display("FAIL nested_blocked: got %b want 0", int_o); end
        end
        wr(3'd4, 32'h0);
        for (int k = 0; k < 6 && int_o !== 1'b1; k++) tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL nested_after_eoi: got %b want 1", int_o); end
        handshake(vv, v);
        vectors++; if (vv !== 1'b1 || v !== 8'h45) begin miscompares++;
            $display("FAIL nested_second: got vv=%b vec=%h want 1 45", vv, v); end
    endtask

    task automatic test_rotate();
        logic vv; logic [7:0] v; logic [7:0] exp_v [3];
        exp_v = '{8'h40, 8'h41, 8'h40};
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40); wr(3'd1, 32'h3); wr(3'd3, 32'h3);
        irq_i[1:0] = 2'b11;
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 6 && int_o !== 1'b1; k++) tick();
            vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL rotate_int%0d: got %b want 1", r, int_o); end
            handshake(vv, v);
            vectors++; if (vv !== 1'b1 || v !== exp_v[r]) begin miscompares++;
                $display("FAIL rotate_vec%0d: got vv=%b vec=%h want 1 %h", r, vv, v, exp_v[r]); end
        end
        irq_i = '0; tick();
    endtask

    task automatic test_spurious();
        logic [31:0] d;
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40); wr(3'd1, 32'h40);
        irq_i[6] = 1'b1; tick(); tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL spur_level_int: got %b want 1", int_o); end
        irq_i[6] = 1'b0; tick();
        inta_i = 1'b1; tick(); tick();
        inta_i = 1'b1; tick();
        vectors++; if (vec_valid_o !== 1'b1 || vec_o !== 8'h47) begin miscompares++;
            $display("FAIL spur_vec: got vv=%b vec=%h want 1 47", vec_valid_o, vec_o); end
        tick();
        rd(3'd6, d);
        vectors++; if (d !== 32'h0) begin miscompares++; $display("FAIL spur_isr: got %h want 0", d); end
    endtask

    task automatic test_preempt();
        logic [31:0] d; logic vv; logic [7:0] v;
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40);
        irq_i[4] = 1'b1; tick(); irq_i = '0; tick();
        handshake(vv, v);
        vectors++; if (v !== 8'h44) begin miscompares++; $display("FAIL preempt_first: got %h want 44", v); end
        irq_i[1] = 1'b1; tick(); irq_i = '0;
        for (int k = 0; k < 4 && int_o !== 1'b1; k++) tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL preempt_int: got %b want 1", int_o); end
        handshake(vv, v);
        vectors++; if (vv !== 1'b1 || v !== 8'h41) begin miscompares++;
            $display("FAIL preempt_vec: got vv=%b vec=%h want 1 41", vv, v); end
        irq_i[7] = 1'b1; tick(); irq_i = '0;
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (int_o !== 1'b0) begin miscompares++; $display("FAIL preempt_low_blocked: got %b want 0", int_o); end
        end
        wr(3'd4, 32'h104);
        rd(3'd6, d);
        vectors++; if (d !== 32'h02) begin miscompares++; $display("FAIL preempt_spec_eoi: got %h want 02", d); end
        rd(3'd5, d);
        vectors++; if (d !== 32'h80) begin miscompares++; $display("FAIL preempt_irr: got %h want 80", d); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d; logic vv; logic [7:0] v;
        logic [31:0] exp_r [8];
        exp_r = '{32'hFF, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40); wr(3'd3, 32'h2);
        irq_i[3] = 1'b1; tick(); irq_i = '0; tick();
        inta_i = 1'b1; tick(); tick();
        vectors++; if (busy_o !== 1'b1) begin miscompares++; $display("FAIL mid_busy: got %b want 1", busy_o); end
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        vectors++; if ({int_o, vec_valid_o, busy_o} !== 3'b000 || cfg_rdata !== 32'h0) begin miscompares++;
            $display("FAIL mid_async: got int/vv/busy=%b rdata=%h want 000 0", {int_o, vec_valid_o, busy_o}, cfg_rdata); end
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        inta_i = 1'b1; tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++; if (vec_valid_o !== 1'b0) begin miscompares++; $display("FAIL mid_no_vec: got %b want 0", vec_valid_o); end
        end
        inta_i = 1'b1; tick(); tick();
        for (int a = 0; a < 8; a++) begin
            if (a == 4) continue;
            rd(3'(a), d);
            vectors++; if (d !== exp_r[a]) begin miscompares++;
                $display("FAIL mid_reg%0d: got %h want %h", a, d, exp_r[a]); end
        end
        wr(3'd3, 32'h7);
        rd(3'd3, d);
        vectors++; if (d !== {29'd0, SMM_EN, 2'b11}) begin miscompares++;
            $display("FAIL ctrl_bits: got %h want %h", d, {29'd0, SMM_EN, 2'b11}); end
`ifdef PIC_SPECIAL_MASK_EN
        do_reset();
        wr(3'd0, 32'h0); wr(3'd2, 32'h40);
        irq_i[4] = 1'b1; tick(); irq_i = '0; tick();
        handshake(vv, v);
        wr(3'd3, 32'h4); wr(3'd0, 32'h10);
        irq_i[7] = 1'b1; tick(); irq_i = '0;
        for (int k = 0; k < 4 && int_o !== 1'b1; k++) tick();
        vectors++; if (int_o !== 1'b1) begin miscompares++; $display("FAIL smm_int: got %b want 1", int_o); end
        handshake(vv, v);
        vectors++; if (vv !== 1'b1 || v !== 8'h47) begin miscompares++;
            $display("FAIL smm_vec: got vv=%b vec=%h want 1 47", vv, v); end
`else
        vv = 1'b0; v = '0;
`endif
    endtask

    task automatic test_random();
        int op;
        do_reset();
        wr(3'd0, 32'($urandom) & 32'h3F);
        wr(3'd1, 32'($urandom) & 32'hFF);
        wr(3'd2, 32'($urandom) & 32'hFF);
        wr(3'd3, 32'($urandom) & 32'h7);
        for (int c = 0; c < 800; c++) begin
            irq_i = irq_i ^ (8'($urandom) & 8'($urandom) & 8'($urandom));
            if ((m_phase == 0 || m_phase == 2) && $urandom_range(0, 3) == 0) inta_i = 1'b1;
            op = $urandom_range(0, 15);
            if (op == 0) begin
                cfg_we = 1'b1; cfg_addr = 3'd4;
                cfg_wdata = {23'd0, 1'($urandom), 5'd0, 3'($urandom)};
            end else if (op == 1 || op == 2) begin
                cfg_re = 1'b1; cfg_addr = 3'($urandom);
            end else if (op == 3) begin
                cfg_we = 1'b1; cfg_addr = 3'($urandom); cfg_wdata = $urandom;
            end
            tick();
            vectors++; if (int_o !== m_int) begin miscompares++;
                $display("FAIL rand_int c=%0d: got %b want %b", c, int_o, m_int); end
            vectors++; if (busy_o !== m_busy || vec_valid_o !== m_vv) begin miscompares++;
                $display("FAIL rand_busy_vv c=%0d: got %b%b want %b%b", c, busy_o, vec_valid_o, m_busy, m_vv); end
            if (m_vv) begin
                vectors++; if (vec_o !== 8'(m_vec)) begin miscompares++;
                    $display("FAIL rand_vec c=%0d: got %h want %h", c, vec_o, 8'(m_vec)); end
            end
            vectors++; if (cfg_rdata !== m_rdata) begin miscompares++;
                $display("FAIL rand_rdata c=%0d: got %h want %h", c, cfg_rdata, m_rdata); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_nested();
        test_rotate();
        test_spurious();
        test_preempt();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
